csel_adder_pipe: RTL and testbench

//  Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshake.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/csel_adder_pipe_if.sv | 26 ++
 rtl/csel_adder_pipe_segment.sv | 27 ++
 rtl/csel_adder_pipe.sv | 142 ++++++++++++++
 tb/tb_csel_adder_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-select adder: segment count derivation,
// parameter legality check and the per-segment carry record.
package adder_pkg;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit width_ok(input int width, input int seg_w);
        return (seg_w >= 2) && (width % seg_w == 0) && (width / seg_w >= 2);
    endfunction

    // Carry-outs and carries into the segment MSB for the cin=0 / cin=1 candidates.
    typedef struct packed {
        logic co0;
        logic co1;
        logic m0;
        logic m1;
    } seg_carry_t;

endpackage

// File: rtl/csel_adder_pipe_if.sv
// Operand/result handshake bundle for csel_adder_pipe; master drives operands, slave is the adder.
interface csel_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/csel_adder_pipe_segment.sv
// One carry-select segment: both candidate sums plus their carry-out and carry into the MSB.
module csel_segment
    import adder_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    output logic [SEG_W-1:0] s0_o,
    output logic [SEG_W-1:0] s1_o,
    output seg_carry_t       c_o
);
    logic [SEG_W:0] full0;
    logic [SEG_W:0] full1;

    assign full0 = {1'b0, a_i} + {1'b0, b_i};
    assign full1 = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, 1'b1};

    assign s0_o = full0[SEG_W-1:0];
    assign s1_o = full1[SEG_W-1:0];

    // Carry into the MSB falls out of the MSB sum bit: s = a ^ b ^ cin.
    assign c_o.co0 = full0[SEG_W];
    assign c_o.co1 = full1[SEG_W];
    assign c_o.m0  = full0[SEG_W-1] ^ a_i[SEG_W-1] ^ b_i[SEG_W-1];
    assign c_o.m1  = full1[SEG_W-1] ^ a_i[SEG_W-1] ^ b_i[SEG_W-1];
endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor: stage 1 forms per-segment candidates,
// stage 2 ripples the carry across segments only. Bubble-collapsing valid/ready flow control.
module csel_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    csel_adder_pipe_if.slave bus
);
    localparam int NSEG = nseg(WIDTH, SEG_W);

    generate
        if (!width_ok(WIDTH, SEG_W)) begin : g_bad_params
            $error("csel_adder_pipe: WIDTH must be a multiple of SEG_W with at least 2 segments");
        end
    endgenerate

    typedef struct packed {
        logic [SEG_W-1:0] s0;
        logic [SEG_W-1:0] s1;
        seg_carry_t       c;
    } seg_cand_t;

    logic             s1_en;
    logic             s2_en;
    logic             in_fire;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [SEG_W:0]   seg0_full;
    logic             seg0_m;
    seg_cand_t        cand_d [1:NSEG-1];

    logic             s1_valid_q;
    logic [SEG_W-1:0] seg0_sum_q;
    logic             seg0_co_q;
    logic             seg0_m_q;
    seg_cand_t        cand_q [1:NSEG-1];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             carry;
    logic             msb_cin;
    logic             s2_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign s2_en   = ~s2_valid_q | bus.out_ready;
    assign s1_en   = ~s1_valid_q | s2_en;
    assign in_fire = bus.in_valid & s1_en;

    assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0    = bus.in_sub | bus.in_cin;

    // Segment 0 sees the real carry-in, so it needs only one adder.
    assign seg0_full = {1'b0, bus.in_a[SEG_W-1:0]} + {1'b0, b_eff[SEG_W-1:0]}
                     + {{SEG_W{1'b0}}, c0};
    assign seg0_m    = seg0_full[SEG_W-1] ^ bus.in_a[SEG_W-1] ^ b_eff[SEG_W-1];

    genvar gi;
    generate
        for (gi = 1; gi < NSEG; gi++) begin : g_seg
            logic [SEG_W-1:0] s0;
            logic [SEG_W-1:0] s1;
            seg_carry_t       c;

            csel_segment #(.SEG_W(SEG_W)) u_seg (
                .a_i  (bus.in_a[gi*SEG_W +: SEG_W]),
                .b_i  (b_eff[gi*SEG_W +: SEG_W]),
                .s0_o (s0),
                .s1_o (s1),
                .c_o  (c)
            );

            assign cand_d[gi] = '{s0: s0, s1: s1, c: c};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            seg0_sum_q <= seg0_full[SEG_W-1:0];
            seg0_co_q  <= seg0_full[SEG_W];
            seg0_m_q   <= seg0_m;
            cand_q     <= cand_d;
        end
    end

    // msb_cin is overwritten per segment, so it ends up holding the top segment's value.
    always_comb begin
        sum_d              = '0;
        sum_d[SEG_W-1:0]   = seg0_sum_q;
        carry              = seg0_co_q;
        msb_cin            = seg0_m_q;
        for (int k = 1; k < NSEG; k++) begin
            if (carry) begin
                sum_d[k*SEG_W +: SEG_W] = cand_q[k].s1;
                msb_cin                 = cand_q[k].c.m1;
                carry                   = cand_q[k].c.co1;
            end else begin
                sum_d[k*SEG_W +: SEG_W] = cand_q[k].s0;
                msb_cin                 = cand_q[k].c.m0;
                carry                   = cand_q[k].c.co0;
            end
        end
        cout_d = carry;
        ovf_d  = msb_cin ^ carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and randomised checks of csel_adder_pipe at 32/8 and 64/16.
module tb_csel_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    csel_adder_pipe_if #(.WIDTH(32)) bus32 ();
    csel_adder_pipe_if #(.WIDTH(64)) bus64 ();

    csel_adder_pipe #(.WIDTH(32), .SEG_W(8)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    csel_adder_pipe #(.WIDTH(64), .SEG_W(16)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Independent reference: overflow from operand/result sign bits.
    function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] t;
        logic        ov;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + 33'(sub | cin);
        ov = (a[31] == be[31]) && (t[31] != a[31]);
        return {t[31:0], t[32], ov};
    endfunction

    task automatic run_vec32(input string nm, input vec_t v);
        int cyc;
        chk({nm, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
        bus32.in_a = v.a; bus32.in_b = v.b; bus32.in_cin = v.cin; bus32.in_sub = v.sub;
        bus32.in_valid = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus32.in_valid = 1'b0;
            if (bus32.out_valid) break;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'd2);
        chk({nm, "_sum"}, 64'(bus32.out_sum), 64'(v.sum));
        chk({nm, "_cout"}, 64'(bus32.out_cout), 64'(v.cout));
        chk({nm, "_ovf"}, 64'(bus32.out_ovf), 64'(v.ovf));
        $display("txn %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 nm, v.a, v.b, v.cin, v.sub, bus32.out_sum, bus32.out_cout, bus32.out_ovf, cyc);
    endtask

    task automatic run_vec64(input string nm, input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic [63:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
        int cyc;
        bus64.in_a = a; bus64.in_b = b; bus64.in_cin = cin; bus64.in_sub = 1'b0;
        bus64.in_valid = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus64.in_valid = 1'b0;
            if (bus64.out_valid) break;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'd2);
        chk({nm, "_sum"}, bus64.out_sum, exp_sum);
        chk({nm, "_cout"}, 64'(bus64.out_cout), 64'(exp_cout));
        chk({nm, "_ovf"}, 64'(bus64.out_ovf), 64'(exp_ovf));
        $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
                 nm, a, b, cin, bus64.out_sum, bus64.out_cout, bus64.out_ovf);
    endtask

    initial begin
        logic [33:0] exp_q [$];
        logic [33:0] held;
        logic [33:0] got;
        logic        stall_prev;
        logic        acc;
        int          sent;
        int          rcvd;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};

        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0;
        bus32.in_cin = 1'b0; bus32.in_sub = 1'b0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0;
        bus64.in_cin = 1'b0; bus64.in_sub = 1'b0; bus64.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("reset_out_sum", 64'(bus32.out_sum), 64'd0);
        chk("reset_out_cout", 64'(bus32.out_cout), 64'd0);
        chk("reset_out_ovf", 64'(bus32.out_ovf), 64'd0);

        for (int i = 0; i < 10; i++) run_vec32($sformatf("vec%0d", i), vecs[i]);

        // Backpressure stream against the reference model.
        sent = 0; rcvd = 0; stall_prev = 1'b0; acc = 1'b0; held = '0;
        for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
            @(posedge clk); #1;
            if (stall_prev) begin
                chk("stall_valid", 64'(bus32.out_valid), 64'd1);
                chk("stall_hold", 64'({bus32.out_sum, bus32.out_cout, bus32.out_ovf}), 64'(held));
            end
            if (acc) bus32.in_valid = 1'b0;
            if (!bus32.in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                bus32.in_a   = $urandom;
                bus32.in_b   = ($urandom_range(0, 3) == 0) ? ~bus32.in_a : $urandom;
                bus32.in_cin = 1'($urandom_range(0, 1));
                bus32.in_sub = 1'($urandom_range(0, 1));
                bus32.in_valid = 1'b1;
            end
            bus32.out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("stream_in_ready", 64'(bus32.in_ready),
                64'(!(exp_q.size() == 2 && !bus32.out_ready)));
            acc = bus32.in_valid & bus32.in_ready;
            if (bus32.out_valid && bus32.out_ready) begin
                got = {bus32.out_sum, bus32.out_cout, bus32.out_ovf};
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_beat", 64'(got), 64'h3_FFFF_FFFF);
                end else begin
                    chk($sformatf("stream_beat%0d", rcvd), 64'(got), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                $display("txn stream%0d: sum=%h cout=%0d ovf=%0d", rcvd,
                         bus32.out_sum, bus32.out_cout, bus32.out_ovf);
                rcvd++;
            end
            if (acc) begin
                exp_q.push_back(ref32(bus32.in_a, bus32.in_b, bus32.in_cin, bus32.in_sub));
                sent++;
            end
            stall_prev = bus32.out_valid & ~bus32.out_ready;
            held = {bus32.out_sum, bus32.out_cout, bus32.out_ovf};
        end
        chk("stream_received", 64'(rcvd), 64'd100);
        chk("stream_leftover", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus32.out_ready = 1'b0;
        bus32.in_a = 32'h0000_1111; bus32.in_b = 32'h0000_2222; bus32.in_cin = 1'b0; bus32.in_sub = 1'b0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_a = 32'h0000_3333;
        @(posedge clk); #1;
        chk("full_out_valid", 64'(bus32.out_valid), 64'd1);
        chk("full_in_ready", 64'(bus32.in_ready), 64'd0);
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus32.in_ready), 64'd1);
        chk("midrst_outputs", 64'({bus32.out_sum, bus32.out_cout, bus32.out_ovf}), 64'd0);
        $display("txn midrst: out_valid=%0d in_ready=%0d sum=%h",
                 bus32.out_valid, bus32.in_ready, bus32.out_sum);
        bus32.out_ready = 1'b1;
        run_vec32("post_rst", vecs[1]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_alone%0d", i), 64'(bus32.out_valid), 64'd0);
        end

        run_vec64("w64_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
        run_vec64("w64_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
